// File: rtl/full_adder.sv
// Registered, width-parameterised ripple-carry adder: {cout, sum} = a + b + cin.
// REG_OUT selects a one-cycle output register stage or a purely combinational path.
module full_adder #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = cin;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_c[i]   = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;
        logic             valid_q;

        // Capture on valid, otherwise hold the last result and drop valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    sum_q  <= sum_c;
                    cout_q <= carry[WIDTH];
                end
            end
        end

        assign sum       = sum_q;
        assign cout      = cout_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        // No state in this configuration; clock and reset are intentionally unused.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign sum       = sum_c;
        assign cout      = carry[WIDTH];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=8 registered instances plus a WIDTH=4
// combinational instance, checked against an arithmetic reference model.
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;

    logic       a1, b1, c1;
    logic       sum1, cout1, ov1;
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] sum8;
    logic       cout8, ov8;
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] sum4;
    logic       cout4, ov4;

    // Reference model state for the registered instances
    logic       m1_sum, m1_cout;
    logic [7:0] m8_sum;
    logic       m8_cout;
    logic       m_valid;

    int n_cmp;
    int n_err;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .cin(c1),
        .sum(sum1), .cout(cout1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .cin(c8),
        .sum(sum8), .cout(cout8), .out_valid(ov8)
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a4), .b(b4), .cin(c4),
        .sum(sum4), .cout(cout4), .out_valid(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sum1"},  64'(sum1),   64'(m1_sum));
        check({tag, ".cout1"}, 64'(cout1),  64'(m1_cout));
        check({tag, ".ov1"},   64'(ov1),    64'(m_valid));
        check({tag, ".sum8"},  64'(sum8),   64'(m8_sum));
        check({tag, ".cout8"}, 64'(cout8),  64'(m8_cout));
        check({tag, ".ov8"},   64'(ov8),    64'(m_valid));
    endtask

    // Check the combinational instance, update the model, clock once, check registers.
    task automatic tick(input string tag);
        logic [1:0] t1;
        logic [8:0] t8;
        logic [4:0] t4;
        #1;
        t4 = 5'(a4) + 5'(b4) + 5'(c4);
        check({tag, ".sum4"},  64'(sum4),  64'(t4[3:0]));
        check({tag, ".cout4"}, 64'(cout4), 64'(t4[4]));
        check({tag, ".ov4"},   64'(ov4),   64'(in_valid));
        if (in_valid) begin
            t1 = 2'(a1) + 2'(b1) + 2'(c1);
            t8 = 9'(a8) + 9'(b8) + 9'(c8);
            m1_sum  = t1[0];
            m1_cout = t1[1];
            m8_sum  = t8[7:0];
            m8_cout = t8[8];
        end
        m_valid = in_valid;
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic model_reset();
        m1_sum  = 1'b0;
        m1_cout = 1'b0;
        m8_sum  = 8'h00;
        m8_cout = 1'b0;
        m_valid = 1'b0;
    endtask

    logic [2:0] tt_in  [8];
    logic [1:0] tt_out [8];
    logic [7:0] w_a [3];
    logic [7:0] w_b [3];
    logic       w_c [3];
    logic [8:0] w_exp [3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        tt_in  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        tt_out = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        w_a   = '{8'hFF, 8'hFF, 8'h12};
        w_b   = '{8'h01, 8'hFF, 8'h34};
        w_c   = '{1'b0, 1'b1, 1'b1};
        w_exp = '{9'h100, 9'h1FF, 9'h047};

        // Reset with all-ones inputs, before any clock edge
        rst_n = 1'b0;
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b0;
        model_reset();
        #3;
        check_regs("reset");
        check("reset.comb_sum4",  64'(sum4),  64'h1);
        check("reset.comb_cout4", 64'(cout4), 64'h1);
        check("reset.comb_ov4",   64'(ov4),   64'h1);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive WIDTH=1 truth table, with the WIDTH=8 wrap vectors alongside
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = tt_in[i];
            if (i < 3) begin
                a8 = w_a[i]; b8 = w_b[i]; c8 = w_c[i];
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            end
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            in_valid = 1'b1;
            tick("tt");
            check("tt.table", 64'({sum1, cout1}), 64'(tt_out[i]));
            if (i < 3) check("wrap8.table", 64'({cout8, sum8}), 64'(w_exp[i]));
        end

        // Hold: result 1, then invalid cycles with changed inputs
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; in_valid = 1'b1;
        tick("hold_load");
        for (int i = 0; i < 3; i++) begin
            a1 = 1'b1; b1 = 1'b1; in_valid = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick("hold");
            check("hold.sum1_const", 64'(sum1), 64'h1);
        end

        // REG_OUT=0 directed case
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b0; in_valid = 1'b1;
        #1;
        check("comb.sum4",  64'(sum4),  64'h1);
        check("comb.cout4", 64'(cout4), 64'h1);
        check("comb.ov4",   64'(ov4),   64'h1);

        // Randomized stream
        for (int i = 0; i < 200; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            in_valid = ($urandom_range(3, 0) != 0);
            tick("rand");
        end

        // Mid-stream reset between edges
        in_valid = 1'b1;
        a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        tick("pre_rst");
        a8 = 8'h77; b8 = 8'h11; c8 = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("midrst");
        @(posedge clk);
        #1;
        check_regs("midrst_edge");
        rst_n = 1'b1;
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
        tick("post_rst");
        check("post_rst.sum8",  64'(sum8),  64'h00);
        check("post_rst.cout8", 64'(cout8), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
